// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with programmable bit period, byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          ser_rx,
    input  logic [DIV_W-1:0]              clkdiv,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff, cnt_run;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic             tick, push_req, push_ok, pop, set_fe, set_ovr;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             par_ok;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d, parity_err_q, parity_err_d, set_pe;
    assign par_ok = ~par_bad_q;
`else
    assign par_ok = 1'b1;
`endif

    // Very short periods leave no room to find the bit centre.
    assign div_eff = (clkdiv < DIV_W'(4)) ? DIV_W'(4) : clkdiv;
    assign tick    = (cnt_q == '0);
    assign cnt_run = tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        set_fe    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        set_pe    = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rx_s_q) begin
                div_d   = div_eff;
                cnt_d   = (div_eff >> 1) - DIV_W'(1);
                state_d = START;
            end
            START: begin
                cnt_d = cnt_run;
                if (tick) begin
                    if (rx_s_q) state_d = IDLE;
                    else begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_run;
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_run;
                if (tick) begin
                    par_bad_d = ^{rx_s_q, shift_q};
                    set_pe    = ^{rx_s_q, shift_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_run;
                if (tick) begin
                    if (rx_s_q) begin
                        push_req = par_ok;
                        state_d  = IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO can still take a byte when the consumer pops on the same edge.
    assign pop     = rx_valid & rx_ready;
    assign push_ok = push_req & ((count_q < CW'(FIFO_DEPTH)) | pop);
    assign set_ovr = push_req & ~push_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        frame_err_d = set_fe  | (frame_err_q & ~err_clear);
        overrun_d   = set_ovr | (overrun_q   & ~err_clear);
`ifdef UART_RX_PARITY_EN
        parity_err_d = set_pe | (parity_err_q & ~err_clear);
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= DIV_W'(4);
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= ser_rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            count_q     <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= (state_q == IDLE) ? 1'b0 : par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign rx_busy    = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive end of the UART link that the testbench UART transmitter drives on mprj_io[5] (uart_rx).
- Sits in the user project area and decodes 8N1 serial frames, LSB first, with a programmable bit period.
- Received bytes are buffered in a small FIFO and handed to the firmware/Wishbone side with a valid/ready handshake.
- Framing errors and overruns are reported as sticky flags.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; must be a power of 2, at least 2.
- DIV_W, 16, width of the clkdiv input.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- resetb  input  1  synchronous, active-low reset.
- ser_rx  input  1  asynchronous serial line; idles high.
- clkdiv  input  DIV_W  bit period in clock cycles.
- rx_data  output  8  byte at the FIFO head.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head byte.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of stored bytes.
- rx_busy  output  1  a frame is in progress (state is not IDLE).
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- err_clear  input  1  single-cycle pulse that clears both sticky flags.

Behaviour:
- Reset, while resetb=0 at a clock edge:
  - all outputs are 0, the FIFO is emptied and the state goes to IDLE;
  - the synchronizer flops are loaded with 1;
  - a reset mid-frame discards the partial byte.
- Input synchronization:
  - ser_rx passes through 2 flops to form rx_s; all decoding uses rx_s.
- Bit period:
  - div_l is latched from clkdiv at start detection; clkdiv changes mid-frame are ignored;
  - a latched value below 4 is forced to 4.
- Counter:
  - cnt counts down; a "tick" occurs when cnt==0, and cnt reloads to div_l-1 on each tick.
- FSM, states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rx_s==0, set cnt=(div_l>>1)-1 and go to START.
  - START: on the tick (mid start bit), if rx_s==1 it is a false start and the FSM returns to IDLE with no flags set; otherwise bit_idx=0 and the FSM goes to DATA.
  - DATA: on each tick, shift={rx_s, shift[7:1]} and increment bit_idx; after the 8th sample go to STOP.
  - STOP: on the tick, if rx_s==1 push the shift register and go to IDLE. If rx_s==0, set frame_err, drop the byte and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A line held low never re-triggers a start.
- Latency:
  - the byte appears on rx_data/rx_valid the cycle after the stop-bit sample edge, if the FIFO was empty;
  - the first start-bit falling edge at the pin to the push edge is about 2 + 9.5×div_l cycles.
- FIFO:
  - circular pointers; rx_data is the head entry, which is 0 when the FIFO is empty;
  - a pop occurs when rx_valid & rx_ready; rx_ready while empty is ignored;
  - push and pop in the same cycle keep the count unchanged, and when the FIFO is full the push is accepted because the pop frees a slot;
  - a push while full with no pop drops the new byte, sets overrun, and keeps the old contents.
- Sticky flags:
  - err_clear clears frame_err and overrun;
  - if a set event occurs in the same cycle as err_clear, the set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - adds a PARITY state between DATA and STOP that samples one even-parity bit;
  - adds output parity_err (sticky, cleared by err_clear, set wins on collision);
  - a byte with bad parity is dropped and sets parity_err; the FSM then continues to STOP normally.
- Undefined:
  - frames are 8N1 only;
  - there is no parity_err port and no PARITY state.

Test Plan:
- clkdiv=16: send 0x3D (61) with rx_ready=1 → rx_valid pulses for one cycle with rx_data=0x3D, frame_err=0, overrun=0.
- clkdiv=16, rx_ready=0: send 0x01, 0x02, 0x03, 0x04, 0x05 → fifo_count=4, overrun=1; then pops return 0x01..0x04 in order; err_clear then gives overrun=0.
- Glitch: ser_rx low for 5 cycles with clkdiv=16 → no push, rx_busy returns to 0, no flags set.
- Stop bit forced low: send 0xA5 with stop=0, then hold low for 3 bit periods → frame_err=1, fifo_count=0; the next valid frame 0x5A is received correctly after the line returns high.
- Simultaneous events:
  - FIFO full, pop and push on the same edge → fifo_count stays 4, overrun=0;
  - err_clear on the same cycle as an overrun → overrun=1.
- Reset mid-frame: assert resetb=0 for 1 cycle after 4 data bits → all outputs 0; the next frame 0xC3 is received intact.
